// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-RAM bus responder: FSM states, opcodes, frame layout.
package spi_ram_pkg;

  localparam int unsigned FRAME_W        = 32;
  localparam int unsigned DATA_START_BIT = 24;
  localparam int unsigned BIT_CNT_W      = 5;
  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned DATA_W         = 8;

  localparam logic [7:0] CMD_READ_DEF  = 8'h03;
  localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  // One serial transaction as it appears on MOSI, MSB first.
  typedef struct packed {
    logic [7:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

  function automatic frame_t build_frame(input logic [7:0]        cmd,
                                         input logic [ADDR_W-1:0] addr,
                                         input logic [DATA_W-1:0] data);
    frame_t f;
    f.cmd  = cmd;
    f.addr = addr;
    f.data = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// SCLK divider, 32-bit MOSI shift register, bit counter and MISO byte capture.
module spi_shifter
  import spi_ram_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               miso_i,
  output logic               sclk_o,
  output logic               mosi_o,
  output logic               busy_o,
  output logic               last_o,
  output logic [DATA_W-1:0]  rx_byte_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic                 arm_q,  arm_d;
  logic                 busy_q, busy_d;
  logic                 sclk_q, sclk_d;
  logic                 last_q, last_d;
  logic [DIV_W-1:0]     div_q,  div_d;
  logic [BIT_CNT_W-1:0] bit_q,  bit_d;
  logic [FRAME_W-1:0]   sh_q,   sh_d;
  logic [DATA_W-1:0]    rx_q,   rx_d;

  // Phase sequencing: one arm cycle (chip-select setup), then per bit a low and a high phase.
  always_comb begin
    arm_d  = arm_q;
    busy_d = busy_q;
    sclk_d = sclk_q;
    last_d = 1'b0;
    div_d  = div_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    if (start_i) begin
      arm_d  = 1'b1;
      busy_d = 1'b1;
      sclk_d = 1'b0;
      div_d  = '0;
      bit_d  = '0;
      sh_d   = frame_i;
      rx_d   = '0;
    end else if (busy_q) begin
      if (arm_q) begin
        arm_d = 1'b0;
      end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          // End of high phase: falling edge, advance MOSI, capture MISO in the data byte.
          sclk_d = 1'b0;
          sh_d   = {sh_q[FRAME_W-2:0], 1'b0};
          if (bit_q >= BIT_CNT_W'(DATA_START_BIT)) begin
            rx_d = {rx_q[DATA_W-2:0], miso_i};
          end
          if (bit_q == BIT_CNT_W'(FRAME_W - 1)) begin
            busy_d = 1'b0;
            last_d = 1'b1;
            bit_d  = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q  <= 1'b0;
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      last_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      rx_q   <= '0;
    end else begin
      arm_q  <= arm_d;
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      last_q <= last_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = sh_q[FRAME_W-1];
  assign busy_o    = busy_q;
  assign last_o    = last_q;
  assign rx_byte_o = rx_q;

endmodule

// File: rtl/spi_ram_responder.sv
// CPU memory-bus responder: each bus request becomes one byte-mode SPI-RAM frame.
module spi_ram_responder
  import spi_ram_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 1,
  parameter logic [7:0]  CMD_READ  = CMD_READ_DEF,
  parameter logic [7:0]  CMD_WRITE = CMD_WRITE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_address,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_read,
  input  logic              bus_write,
  output logic              bus_done,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  state_e            state_q, state_d;
  logic              cs_n_q,  cs_n_d;
  logic              done_q,  done_d;
  logic              wr_q,    wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              req_c;
  logic              start_c;
  frame_t            frame_c;
  logic              shf_busy;
  logic              shf_last;
  logic [DATA_W-1:0] shf_rx;

  // Write wins when both request lines are high; the frame is the only copy of addr/wdata.
  assign req_c   = bus_read | bus_write;
  assign start_c = (state_q == ST_IDLE) && req_c;
  assign frame_c = build_frame(bus_write ? CMD_WRITE : CMD_READ,
                               bus_address,
                               bus_write ? bus_wdata : 8'h00);

  spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_c),
    .frame_i   (frame_c),
    .miso_i    (spi_miso),
    .sclk_o    (spi_sclk),
    .mosi_o    (spi_mosi),
    .busy_o    (shf_busy),
    .last_o    (shf_last),
    .rx_byte_o (shf_rx)
  );

  // Bus handshake FSM: accept, frame, pulse done, then wait for the request to drop.
  always_comb begin
    state_d = state_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          wr_d    = bus_write;
          cs_n_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (shf_busy) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shf_last) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
          if (!wr_q) begin
            rdata_d = shf_rx;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // A request still held from the finished transaction must drop before re-arming.
        if (!req_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  // Handshake state and registered bus/chip-select outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  assign spi_cs_n  = cs_n_q;
  assign bus_done  = done_q;
  assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Bench for spi_ram_responder: lane 0 runs CLK_DIV=1, lane 1 runs CLK_DIV=3.
module tb_spi_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd    [2];
  logic        wr    [2];
  logic        done  [2];
  logic        csn   [2];
  logic        sclk  [2];
  logic        mosi  [2];
  logic        miso  [2];
  logic [15:0] addr  [2];
  logic [7:0]  wdata [2];
  logic [7:0]  rdata [2];

  logic [7:0]  mem [0:65535];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc [2];

  always #5 clk = ~clk;

  spi_ram_responder #(.CLK_DIV(1)) dut0 (
    .clk(clk), .rst(rst), .bus_address(addr[0]), .bus_wdata(wdata[0]), .bus_rdata(rdata[0]),
    .bus_read(rd[0]), .bus_write(wr[0]), .bus_done(done[0]), .spi_cs_n(csn[0]),
    .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  spi_ram_responder #(.CLK_DIV(3)) dut1 (
    .clk(clk), .rst(rst), .bus_address(addr[1]), .bus_wdata(wdata[1]), .bus_rdata(rdata[1]),
    .bus_read(rd[1]), .bus_write(wr[1]), .bus_done(done[1]), .spi_cs_n(csn[1]),
    .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  function automatic int div_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic void chk(input string name, input int g, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lane%0d cyc%0d: got %h want %h", name, g, cyc, act, exp);
    end
  endfunction

  // Transaction-level model: when each request is accepted, when done is due, what rdata must be.
  logic        m_busy [2];
  logic        m_rel  [2];
  logic        m_wr   [2];
  int          m_acc  [2];
  int          m_done [2];
  logic [31:0] m_frame[2];
  logic [7:0]  m_byte [2];
  logic [7:0]  m_exp_rd[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        m_busy[g]   = 1'b0;
        m_rel[g]    = 1'b0;
        m_done[g]   = -1;
        m_exp_rd[g] = 8'h00;
      end
    end else begin
      cyc++;
      for (int g = 0; g < 2; g++) begin
        int  d;
        logic req;
        d   = div_of(g);
        req = rd[g] | wr[g];
        if (m_busy[g]) begin
          if (cyc == m_acc[g] + 2 + 64 * d) begin
            m_busy[g] = 1'b0;
            m_rel[g]  = 1'b1;
            m_done[g] = cyc;
            if (!m_wr[g]) m_exp_rd[g] = m_byte[g];
          end
        end else if (m_rel[g]) begin
          if (cyc >= m_done[g] + 2 && !req) m_rel[g] = 1'b0;
        end else if (req) begin
          m_busy[g]  = 1'b1;
          m_acc[g]   = cyc;
          m_wr[g]    = wr[g];
          m_frame[g] = {(wr[g] ? 8'h02 : 8'h03), addr[g], (wr[g] ? wdata[g] : 8'h00)};
          m_byte[g]  = mem[addr[g]];
        end
      end
    end
  end

  // Behavioural SPI RAM (mode 0): captures MOSI on SCLK rise, drives MISO after SCLK fall.
  logic [31:0] r_sh   [2];
  int          r_n    [2];
  logic [7:0]  r_op   [2];
  logic [7:0]  r_byte [2];
  logic        r_sclk_p[2];
  logic        r_csn_p [2];
  logic [31:0] last_frame[2];
  int          last_n [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        r_n[g]      = 0;
        miso[g]     = 1'b0;
        r_sclk_p[g] = 1'b0;
        r_csn_p[g]  = 1'b1;
      end else begin
        if (!csn[g]) begin
          if (sclk[g] && !r_sclk_p[g]) begin
            r_sh[g] = {r_sh[g][30:0], mosi[g]};
            r_n[g]++;
            if (r_n[g] == 8)  r_op[g]   = r_sh[g][7:0];
            if (r_n[g] == 24) r_byte[g] = mem[r_sh[g][15:0]];
          end else if (!sclk[g] && r_sclk_p[g] && r_n[g] >= 24 && r_n[g] < 32
                       && r_op[g] == 8'h03) begin
            int bi;
            bi = 7 - (r_n[g] - 24);
            miso[g] = r_byte[g][bi];
          end
        end else if (!r_csn_p[g]) begin
          last_frame[g] = r_sh[g];
          last_n[g]     = r_n[g];
          if (r_n[g] == 32 && r_op[g] == 8'h02) mem[r_sh[g][23:8]] = r_sh[g][7:0];
          r_n[g]  = 0;
          miso[g] = 1'b0;
        end
        r_sclk_p[g] = sclk[g];
        r_csn_p[g]  = csn[g];
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model timeline.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int d;
      int t;
      d = div_of(g);
      chk("rdata", g, 32'(rdata[g]), 32'(m_exp_rd[g]));
      if (m_busy[g]) begin
        t = cyc - m_acc[g];
        chk("cs_n", g, 32'(csn[g]), 32'(1'b0));
        chk("done", g, 32'(done[g]), 32'(1'b0));
        if (t >= 1 && t <= 64 * d) begin
          chk("sclk", g, 32'(sclk[g]), 32'(((t - 1) % (2 * d)) >= d));
          chk("mosi", g, 32'(mosi[g]), 32'(m_frame[g][31 - (t - 1) / (2 * d)]));
        end else begin
          chk("sclk", g, 32'(sclk[g]), 32'(1'b0));
          if (t == 0) chk("mosi_setup", g, 32'(mosi[g]), 32'(m_frame[g][31]));
        end
      end else begin
        chk("cs_n_idle", g, 32'(csn[g]), 32'(1'b1));
        chk("sclk_idle", g, 32'(sclk[g]), 32'(1'b0));
        chk("done_pulse", g, 32'(done[g]), 32'(cyc == m_done[g]));
      end
    end
  end

  task automatic start_req(input int g, input logic r, input logic w,
                           input logic [15:0] a, input logic [7:0] dd);
    rd[g]      = r;
    wr[g]      = w;
    addr[g]    = a;
    wdata[g]   = dd;
    acc_cyc[g] = cyc + 1;
  endtask

  task automatic drop(input int g);
    rd[g] = 1'b0;
    wr[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done[g] === 1'b1) begin
        lat = cyc - acc_cyc[g];
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL done_timeout lane%0d: no bus_done within %0d cycles", g, budget);
  endtask

  initial begin
    int  lat;
    logic seen;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      rd[g] = 1'b0; wr[g] = 1'b0; addr[g] = 16'h0; wdata[g] = 8'h0;
    end
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFF] = 8'h3C;
    mem[16'h0042] = 8'h81;

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_cs_n",  g, 32'(csn[g]),   32'h1);
      chk("rst_sclk",  g, 32'(sclk[g]),  32'h0);
      chk("rst_mosi",  g, 32'(mosi[g]),  32'h0);
      chk("rst_done",  g, 32'(done[g]),  32'h0);
      chk("rst_rdata", g, 32'(rdata[g]), 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Write 0xA5 to 0x1234.
    start_req(0, 1'b0, 1'b1, 16'h1234, 8'hA5);
    wait_done(0, 300, lat);
    chk("wr_latency", 0, 32'(lat), 32'd66);
    chk("wr_cs_at_done", 0, 32'(csn[0]), 32'h1);
    drop(0);
    repeat (3) @(negedge clk);
    chk("wr_frame", 0, last_frame[0], 32'h0212_34A5);
    chk("wr_rises", 0, 32'(last_n[0]), 32'd32);
    chk("wr_mem", 0, 32'(mem[16'h1234]), 32'hA5);

    // Read from 0xFFFF, request held 5 cycles past done.
    start_req(0, 1'b1, 1'b0, 16'hFFFF, 8'h00);
    wait_done(0, 300, lat);
    chk("rd_latency", 0, 32'(lat), 32'd66);
    chk("rd_data", 0, 32'(rdata[0]), 32'h3C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_cs_n", 0, 32'(csn[0]), 32'h1);
      chk("hold_done", 0, 32'(done[0]), 32'h0);
    end
    chk("rd_frame", 0, last_frame[0], 32'h03FF_FF00);
    drop(0);
    @(negedge clk);
    chk("rd_data_held", 0, 32'(rdata[0]), 32'h3C);
    start_req(0, 1'b1, 1'b0, 16'h1234, 8'h00);
    wait_done(0, 300, lat);
    chk("rd2_latency", 0, 32'(lat), 32'd66);
    chk("rd2_data", 0, 32'(rdata[0]), 32'hA5);
    drop(0);
    repeat (3) @(negedge clk);
    chk("rd2_frame", 0, last_frame[0], 32'h0312_3400);

    // Read and write together; request dropped and inputs changed mid-frame.
    start_req(0, 1'b1, 1'b1, 16'h0100, 8'h5A);
    repeat (10) @(negedge clk);
    drop(0);
    addr[0]  = 16'hBEEF;
    wdata[0] = 8'hFF;
    wait_done(0, 300, lat);
    chk("both_latency", 0, 32'(lat), 32'd66);
    chk("both_rdata_kept", 0, 32'(rdata[0]), 32'hA5);
    repeat (3) @(negedge clk);
    chk("both_frame", 0, last_frame[0], 32'h0201_005A);
    chk("both_mem", 0, 32'(mem[16'h0100]), 32'h5A);
    chk("both_no_beef", 0, 32'(mem[16'hBEEF]), 32'h00);

    // CLK_DIV=3 read of 0x81.
    start_req(1, 1'b1, 1'b0, 16'h0042, 8'h00);
    wait_done(1, 600, lat);
    chk("div3_latency", 1, 32'(lat), 32'd194);
    chk("div3_data", 1, 32'(rdata[1]), 32'h81);
    drop(1);
    repeat (3) @(negedge clk);
    chk("div3_frame", 1, last_frame[1], 32'h0300_4200);
    chk("div3_rises", 1, 32'(last_n[1]), 32'd32);

    // Asynchronous reset in the middle of bit 10 of a write frame.
    start_req(0, 1'b0, 1'b1, 16'h2222, 8'h77);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (r_n[0] >= 10) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reach_bit10", 0, 32'(seen), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_cs_n",  0, 32'(csn[0]),   32'h1);
    chk("arst_sclk",  0, 32'(sclk[0]),  32'h0);
    chk("arst_done",  0, 32'(done[0]),  32'h0);
    chk("arst_mosi",  0, 32'(mosi[0]),  32'h0);
    chk("arst_rdata", 0, 32'(rdata[0]), 32'h0);
    @(negedge clk);
    drop(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_no_write", 0, 32'(mem[16'h2222]), 32'h00);
    start_req(0, 1'b1, 1'b0, 16'h1234, 8'h00);
    wait_done(0, 300, lat);
    chk("post_rst_latency", 0, 32'(lat), 32'd66);
    chk("post_rst_data", 0, 32'(rdata[0]), 32'hA5);
    drop(0);
    repeat (3) @(negedge clk);
    chk("post_rst_frame", 0, last_frame[0], 32'h0312_3400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
